// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM states and frame sampling constants shared by the UART blocks.
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } rx_state_t;
  localparam int MID_TICK = 8;
  localparam int TICKS_PER_BIT = 16;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic re, we;
  assign empty = wptr == rptr;
  assign full = wptr == {~rptr[AW], rptr[AW-1:0]};
  assign re = rd && !empty;
  assign we = wr && (!full || re);
  assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];
  always_ff @(posedge clk)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (we) wptr <= wptr + 1'b1;
      if (re) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (we) mem[wptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8-N-1 receiver feeding a FWFT byte FIFO.
// UART_RX_PARITY_EN switches to 8-E-1 and adds the parity_err flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV = 26,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX,
  input  logic       rd,
  output logic [7:0] rd_data,
  output logic       valid,
  output logic       full,
  output logic       overrun,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  input  logic       clr_err
);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam int TW = $clog2(TICKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif
  rx_state_t state, next;
  logic [1:0] sync;
  logic rxs, rxs_q, fall, start, tick, sample, empty;
  logic good_stop, push, set_over, set_frame;
  logic [PW-1:0] presc;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic [DATA_BITS-1:0] shift;
  assign rxs = sync[1];
  assign fall = rxs_q & ~rxs;
  assign start = state == IDLE && fall;
  assign tick = presc == PMAX;
  // the 4-bit tick counter wraps every bit, so mid-bit is always the same count
  assign sample = tick && tcnt == TW'(MID_TICK - 1);
  assign valid = ~empty;
  always_ff @(posedge clk)
    if (reset) begin
      sync <= 2'b11;
      rxs_q <= 1'b1;
      presc <= '0;
      tcnt <= '0;
      bcnt <= '0;
      shift <= '0;
    end else begin
      sync <= {sync[0], RX};
      rxs_q <= rxs;
      presc <= (start || tick) ? '0 : presc + 1'b1;
      tcnt <= start ? '0 : tick ? tcnt + 1'b1 : tcnt;
      bcnt <= start ? '0 : (state == DATA && sample) ? bcnt + 1'b1 : bcnt;
      if (state == DATA && sample) shift <= {rxs, shift[DATA_BITS-1:1]};
    end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (fall) next = START;
      START:   if (sample) next = rxs ? IDLE : DATA;
      DATA:    if (sample && bcnt == BW'(DATA_BITS - 1)) next = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      PARITY:  if (sample) next = STOP;
`endif
      STOP:    if (sample) next = rxs ? IDLE : BREAK;
      BREAK:   if (rxs) next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    good_stop = state == STOP && sample && rxs;
    push = good_stop && (!full || rd);
    set_over = good_stop && full && !rd;
    set_frame = state == STOP && sample && !rxs;
  end
  always_ff @(posedge clk)
    if (reset) begin
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun <= set_over | (overrun & ~clr_err);
      frame_err <= set_frame | (frame_err & ~clr_err);
    end
`ifdef UART_RX_PARITY_EN
  logic set_par;
  assign set_par = state == PARITY && sample && (rxs != ^shift);
  always_ff @(posedge clk)
    if (reset) parity_err <= 1'b0;
    else parity_err <= set_par | (parity_err & ~clr_err);
`endif
  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr(push),
    .wr_data(shift),
    .rd(rd),
    .rd_data(rd_data),
    .empty(empty),
    .full(full)
  );
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames against a queue-based receiver model.
module tb_uart_rx;
  localparam int DIV = 4;
  localparam int DEPTH = 4;
  localparam int BIT = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  typedef struct {
    int t;
    int kind;
    logic [7:0] d;
  } ev_t;
  logic clk = 0, reset = 1, RX = 1, rd = 0, clr_err = 0;
  logic [7:0] rd_data;
  logic valid, full, overrun, frame_err;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif
  int checks = 0, failures = 0, cyc = 0;
  ev_t pend[$];
  logic [7:0] q[$];
  logic m_ov = 0, m_fe = 0, m_pe = 0;
  logic done = 0;
  logic [7:0] rd_v;
  logic st_v, par_v;

  uart_rx #(.DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .RX(RX),
    .rd(rd),
    .rd_data(rd_data),
    .valid(valid),
    .full(full),
    .overrun(overrun),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic hold(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  // Frame k-th sample lands (8+16k)*DIV after T0, T0 being 2 cycles after the pin edge;
  // the resulting register update is one more edge later.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    int n;
    @(posedge clk);
    #1;
    n = cyc;
`ifdef UART_RX_PARITY_EN
    if (par != ^d) pend.push_back(ev_t'{n + 3 + (8 + 16 * 9) * DIV, 2, d});
`endif
    pend.push_back(ev_t'{n + 3 + (8 + 16 * NB) * DIV, stop ? 0 : 1, d});
    RX = 0;
    hold(BIT);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      hold(BIT);
    end
`ifdef UART_RX_PARITY_EN
    RX = par;
    hold(BIT);
`endif
    RX = stop;
    hold(BIT);
    RX = 1;
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, 1'b1, ^d);
  endtask

  task automatic pop_expect(input logic [7:0] exp);
    chk("pop_valid", valid, 1);
    chk("pop_data", rd_data, exp);
    rd = 1;
    hold(1);
    rd = 0;
  endtask

  task automatic clear_flags;
    clr_err = 1;
    hold(1);
    clr_err = 0;
  endtask

  // Reference model: byte queue plus sticky flags, advanced once per clock edge.
  always @(posedge clk) begin
    ev_t e;
    logic so, sf, sp, has_push;
    logic [7:0] pd;
    cyc = cyc + 1;
    if (reset) begin
      q.delete();
      pend.delete();
      m_ov = 0;
      m_fe = 0;
      m_pe = 0;
    end else begin
      so = 0;
      sf = 0;
      sp = 0;
      has_push = 0;
      pd = 0;
      while (pend.size() > 0 && pend[0].t == cyc) begin
        e = pend.pop_front();
        if (e.kind == 0) begin
          if (q.size() < DEPTH || rd) begin
            has_push = 1;
            pd = e.d;
          end else so = 1;
        end else if (e.kind == 1) sf = 1;
        else sp = 1;
      end
      if (rd && q.size() > 0) void'(q.pop_front());
      if (has_push) q.push_back(pd);
      m_ov = so | (m_ov & !clr_err);
      m_fe = sf | (m_fe & !clr_err);
      m_pe = sp | (m_pe & !clr_err);
    end
  end

  always @(negedge clk)
    if (cyc > 0 && failures < 100) begin
      chk("valid", valid, q.size() > 0);
      chk("full", full, q.size() == DEPTH);
      if (q.size() > 0) chk("rd_data", rd_data, q[0]);
      chk("overrun", overrun, m_ov);
      chk("frame_err", frame_err, m_fe);
`ifdef UART_RX_PARITY_EN
      chk("parity_err", parity_err, m_pe);
`endif
    end

  initial begin
    hold(3);
    reset = 0;
    chk("rst_valid", valid, 0);
    chk("rst_full", full, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    hold(5);
    // single byte with exact valid latency
    fork
      send(8'h55);
      begin
        @(posedge clk);
        #1;
        hold(2 + (8 + 16 * NB) * DIV);
        chk("lat_before", valid, 0);
        hold(1);
        chk("lat_valid", valid, 1);
        chk("lat_data", rd_data, 8'h55);
      end
    join
    rd = 1;
    hold(1);
    rd = 0;
    chk("single_popped", valid, 0);
    // glitch shorter than half a bit
    RX = 0;
    hold(3 * DIV);
    RX = 1;
    hold(12 * DIV);
    chk("glitch_valid", valid, 0);
    chk("glitch_overrun", overrun, 0);
    chk("glitch_frame", frame_err, 0);
    // framing error then recovery
    send_frame(8'hA3, 1'b0, 1'b0);
    hold(4);
    chk("fe_set", frame_err, 1);
    chk("fe_empty", valid, 0);
    send(8'h3C);
    pop_expect(8'h3C);
    clear_flags();
    chk("fe_clr", frame_err, 0);
    // overrun
    for (int i = 1; i <= 5; i++) send(8'(i));
    chk("ovr_full", full, 1);
    chk("ovr_flag", overrun, 1);
    for (int i = 1; i <= 4; i++) pop_expect(8'(i));
    chk("ovr_drained", valid, 0);
    clear_flags();
    chk("ovr_clr", overrun, 0);
    // push and pop together while full
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    fork
      send(8'h99);
      begin
        @(posedge clk);
        #1;
        hold(2 + (8 + 16 * NB) * DIV);
        rd = 1;
        hold(1);
        rd = 0;
      end
    join
    chk("sim_overrun", overrun, 0);
    chk("sim_full", full, 1);
    pop_expect(8'h22);
    pop_expect(8'h33);
    pop_expect(8'h44);
    pop_expect(8'h99);
    // reset during data bit 4
    send_frame(8'h10, 1'b0, 1'b1);
    send(8'h5A);
    rd_v = 8'h7E;
    @(posedge clk);
    #1;
    RX = 0;
    hold(BIT);
    for (int i = 0; i < 4; i++) begin
      RX = rd_v[i];
      hold(BIT);
    end
    RX = rd_v[4];
    hold(BIT / 2);
    reset = 1;
    RX = 1;
    hold(2);
    reset = 0;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_data", rd_data, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_frame", frame_err, 0);
    hold(20);
    send(8'h7E);
    pop_expect(8'h7E);
    // randomized traffic with concurrent reads and flag clears
    fork
      begin
        repeat (25) begin
          rd_v = 8'($urandom);
          st_v = $urandom_range(0, 7) != 0;
          par_v = ($urandom_range(0, 5) == 0) ? ~^rd_v : ^rd_v;
          hold($urandom_range(1, 40));
          send_frame(rd_v, st_v, par_v);
        end
        done = 1;
      end
      begin
        while (!done) begin
          rd = $urandom_range(0, 3) == 0;
          clr_err = $urandom_range(0, 31) == 0;
          hold(1);
        end
        rd = 0;
        clr_err = 0;
      end
    join
    repeat (DEPTH + 1) begin
      rd = 1;
      hold(1);
    end
    rd = 0;
    hold(2);
    chk("rand_drained", valid, 0);
`ifdef UART_RX_PARITY_EN
    clear_flags();
    send_frame(8'h07, 1'b1, 1'b0);
    hold(2);
    chk("par_bad", parity_err, 1);
    pop_expect(8'h07);
    clear_flags();
    chk("par_clr", parity_err, 0);
    send_frame(8'h07, 1'b1, 1'b1);
    hold(2);
    chk("par_ok", parity_err, 0);
    pop_expect(8'h07);
`endif
    hold(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
